// File: rtl/serial_subtractor_ctrl.sv
// serial_subtractor_ctrl: bit-serial A-B unit behind a start/done handshake.
// Operands are captured on start acceptance and processed LSB first, one bit
// per cycle, through two half subtractors with a registered borrow chain.
// Optional feature macro: SERIAL_SUB_OVF_EN adds the signed-overflow output ovf.

// Single-bit half subtractor: d = x - y, bo = borrow out.
module half_subtractor (
    input  logic x,
    input  logic y,
    output logic d,
    output logic bo
);
    assign d  = x ^ y;
    assign bo = ~x & y;
endmodule

module serial_subtractor_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    // Counter must hold 0..WIDTH-1; sized for WIDTH+1 values so WIDTH=1 still works.
    localparam int              CW   = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-1:0] res;
    logic             brw;
    logic [CW-1:0]    cnt;

    logic             d0;
    logic             bo0;
    logic             d1;
    logic             bo1;
    logic             brw_next;
    logic [WIDTH-1:0] res_next;

`ifdef SERIAL_SUB_OVF_EN
    logic             a_msb;
    logic             b_msb;
`endif

    // First stage subtracts the current operand bits, second stage folds in
    // the borrow carried from the previous bit.
    half_subtractor hs0 (
        .x  (sa[0]),
        .y  (sb[0]),
        .d  (d0),
        .bo (bo0)
    );

    half_subtractor hs1 (
        .x  (d0),
        .y  (brw),
        .d  (d1),
        .bo (bo1)
    );

    assign brw_next = bo0 | bo1;

    // New result bit enters at the MSB; after WIDTH shifts bit 0 sits at the LSB.
    generate
        if (WIDTH == 1) begin : g_res_one
            assign res_next = d1;
        end else begin : g_res_many
            assign res_next = {d1, res[WIDTH-1:1]};
        end
    endgenerate

    // Control FSM, serial datapath registers and registered result outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            sa         <= '0;
            sb         <= '0;
            res        <= '0;
            brw        <= 1'b0;
            cnt        <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            diff       <= '0;
            borrow_out <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            a_msb      <= 1'b0;
            b_msb      <= 1'b0;
            ovf        <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state <= RUN;
                        busy  <= 1'b1;
                        sa    <= a;
                        sb    <= b;
                        res   <= '0;
                        brw   <= 1'b0;
                        cnt   <= '0;
`ifdef SERIAL_SUB_OVF_EN
                        a_msb <= a[WIDTH-1];
                        b_msb <= b[WIDTH-1];
`endif
                    end
                end

                RUN: begin
                    sa  <= sa >> 1;
                    sb  <= sb >> 1;
                    res <= res_next;
                    brw <= brw_next;
                    cnt <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        // Last bit: publish the completed result in the same edge.
                        state      <= DONE;
                        busy       <= 1'b0;
                        done       <= 1'b1;
                        diff       <= res_next;
                        borrow_out <= brw_next;
`ifdef SERIAL_SUB_OVF_EN
                        ovf        <= (a_msb != b_msb) & (res_next[WIDTH-1] != a_msb);
`endif
                    end
                end

                DONE: begin
                    // Start is ignored here; the requester must hold or re-issue it.
                    state <= IDLE;
                    done  <= 1'b0;
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor_ctrl.sv
// Scoreboard bench for serial_subtractor_ctrl (WIDTH=8 main instance plus a
// WIDTH=1 instance). Driver models acceptance timing and pushes expected
// results; a negedge monitor pops and compares whenever done is seen.
module tb_serial_subtractor_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         borrow_out;
`ifdef SERIAL_SUB_OVF_EN
    logic         ovf;
    logic         ovf1;
`endif

    logic         start1 = 1'b0;
    logic [0:0]   a1 = '0;
    logic [0:0]   b1 = '0;
    logic         busy1;
    logic         done1;
    logic [0:0]   diff1;
    logic         borrow1;

    always #5 clk = ~clk;

    serial_subtractor_ctrl #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .a          (a),
        .b          (b),
        .busy       (busy),
        .done       (done),
        .diff       (diff),
        .borrow_out (borrow_out)
`ifdef SERIAL_SUB_OVF_EN
        ,
        .ovf        (ovf)
`endif
    );

    serial_subtractor_ctrl #(.WIDTH(1)) dut1 (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start1),
        .a          (a1),
        .b          (b1),
        .busy       (busy1),
        .done       (done1),
        .diff       (diff1),
        .borrow_out (borrow1)
`ifdef SERIAL_SUB_OVF_EN
        ,
        .ovf        (ovf1)
`endif
    );

    typedef struct {
        int           due;
        logic [W-1:0] d;
        logic         bo;
        logic         ov;
    } exp_t;

    exp_t         sb_q[$];
    exp_t         mon_e;
    int           n_cmp = 0;
    int           n_err = 0;
    int           edge_cnt = 0;
    int           next_free = 1;
    int           cur_k = -1000;
    logic [W-1:0] hold_d = '0;
    logic         hold_bo = 1'b0;
    logic         hold_ov = 1'b0;
    logic         exp_busy;
    logic         exp_done;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", name, act, exp, edge_cnt);
        end
    endtask

    // Reference: plain integer subtraction, wrapped to W bits.
    function automatic exp_t ref_sub(input int due, input logic [W-1:0] av, input logic [W-1:0] bv);
        exp_t e;
        int   r;
        r     = int'(av) - int'(bv);
        e.due = due;
        e.d   = W'(r + (1 << W));
        e.bo  = (r < 0);
        e.ov  = (av[W-1] != bv[W-1]) && (e.d[W-1] != av[W-1]);
        return e;
    endfunction

    // One clock of stimulus; the model decides whether this edge accepts.
    task automatic drive(input logic s, input logic [W-1:0] av, input logic [W-1:0] bv);
        @(negedge clk);
        start = s;
        a     = av;
        b     = bv;
        @(posedge clk);
        edge_cnt++;
        if (s && edge_cnt >= next_free) begin
            sb_q.push_back(ref_sub(edge_cnt + W, av, bv));
            cur_k     = edge_cnt;
            next_free = edge_cnt + W + 2;
            $display("op @edge %0d: a=0x%02h b=0x%02h", edge_cnt, av, bv);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, W'($urandom), W'($urandom));
    endtask

    // Monitor: handshake timing every cycle, result check on done, hold otherwise.
    always @(negedge clk) begin
        if (rst_n) begin
            exp_busy = (edge_cnt >= cur_k) && (edge_cnt < cur_k + W);
            exp_done = (edge_cnt == cur_k + W);
            chk("busy", {31'd0, busy}, {31'd0, exp_busy});
            chk("done", {31'd0, done}, {31'd0, exp_done});
            if (done) begin
                if (sb_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL spurious_done: got done=1 expected no pending op (edge %0d)", edge_cnt);
                end else begin
                    mon_e = sb_q.pop_front();
                    chk("done_edge", edge_cnt, mon_e.due);
                    chk("diff", {24'd0, diff}, {24'd0, mon_e.d});
                    chk("borrow_out", {31'd0, borrow_out}, {31'd0, mon_e.bo});
`ifdef SERIAL_SUB_OVF_EN
                    chk("ovf", {31'd0, ovf}, {31'd0, mon_e.ov});
`endif
                    hold_d  = mon_e.d;
                    hold_bo = mon_e.bo;
                    hold_ov = mon_e.ov;
                    $display("done @edge %0d: diff=0x%02h borrow_out=%0d", edge_cnt, diff, borrow_out);
                end
            end
            chk("diff_hold", {24'd0, diff}, {24'd0, hold_d});
            chk("borrow_hold", {31'd0, borrow_out}, {31'd0, hold_bo});
`ifdef SERIAL_SUB_OVF_EN
            chk("ovf_hold", {31'd0, ovf}, {31'd0, hold_ov});
`endif
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_diff", {24'd0, diff}, 32'd0);
        chk("rst_borrow", {31'd0, borrow_out}, 32'd0);
        rst_n = 1'b1;
        next_free = edge_cnt + 1;

        // Directed cases.
        drive(1'b1, 8'd100, 8'd37);  idle(11);
        drive(1'b1, 8'h05, 8'h0A);   idle(11);
        drive(1'b1, 8'h80, 8'h01);   idle(11);
        // start held high continuously: accepted only every W+2 edges.
        for (int i = 0; i < 25; i++) drive(1'b1, 8'h00, 8'h00);
        idle(11);

        // Reset during the 4th RUN cycle after a result of 0x3F.
        drive(1'b1, 8'h40, 8'h01);   idle(11);
        drive(1'b1, 8'h12, 8'h34);   idle(3);
        @(negedge clk);
        chk("pre_reset_diff", {24'd0, diff}, 32'h3F);
        #2 rst_n = 1'b0;
        #1;
        chk("async_busy", {31'd0, busy}, 32'd0);
        chk("async_done", {31'd0, done}, 32'd0);
        chk("async_diff", {24'd0, diff}, 32'd0);
        chk("async_borrow", {31'd0, borrow_out}, 32'd0);
`ifdef SERIAL_SUB_OVF_EN
        chk("async_ovf", {31'd0, ovf}, 32'd0);
`endif
        sb_q.delete();
        hold_d  = '0;
        hold_bo = 1'b0;
        hold_ov = 1'b0;
        cur_k   = -1000;
        @(posedge clk); edge_cnt++;
        @(posedge clk); edge_cnt++;
        #1 rst_n = 1'b1;
        next_free = edge_cnt + 1;
        drive(1'b1, 8'hFF, 8'hFF);   idle(11);

        // Random traffic with random start density and changing operands.
        for (int i = 0; i < 400; i++)
            drive($urandom_range(0, 2) == 0, W'($urandom), W'($urandom));
        idle(12);
        chk("queue_drained", sb_q.size(), 32'd0);

        // WIDTH=1 instance.
        for (int t = 0; t < 2; t++) begin
            @(negedge clk);
            start1 = 1'b1;
            a1     = (t == 0) ? 1'b0 : 1'b1;
            b1     = (t == 0) ? 1'b1 : 1'b0;
            @(posedge clk);
            @(negedge clk);
            start1 = 1'b0;
            chk("w1_busy", {31'd0, busy1}, 32'd1);
            chk("w1_done_early", {31'd0, done1}, 32'd0);
            @(negedge clk);
            chk("w1_done", {31'd0, done1}, 32'd1);
            chk("w1_busy_off", {31'd0, busy1}, 32'd0);
            chk("w1_diff", {31'd0, diff1}, 32'd1);
            chk("w1_borrow", {31'd0, borrow1}, (t == 0) ? 32'd1 : 32'd0);
            $display("w1 op a=%0d b=%0d: diff=%0d borrow_out=%0d", a1, b1, diff1, borrow1);
            @(negedge clk);
            chk("w1_done_pulse", {31'd0, done1}, 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
